// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner: row-by-row scan, 2-flop column synchroniser,
// press/release debounce, and one valid pulse per accepted key.
module keypad_scanner #(
  parameter int unsigned SCAN_DWELL = 4,
  parameter int unsigned DEBOUNCE   = 20,
  parameter int unsigned RELEASE_DB = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] key_col,
  output logic [3:0] key_row,
  output logic [3:0] keypad_input,
  output logic       keypad_valid,
  output logic       key_held
);

  localparam int unsigned DW_W = $clog2(SCAN_DWELL);
  localparam int unsigned DB_W = $clog2(DEBOUNCE);
  localparam int unsigned RL_W = $clog2(RELEASE_DB);

  localparam logic [DW_W-1:0] DW_LAST = DW_W'(SCAN_DWELL - 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE - 1);
  localparam logic [RL_W-1:0] RL_LAST = RL_W'(RELEASE_DB - 1);

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_HELD
  } state_e;

  state_e          state_q;
  logic [2:0]      sync1_q;
  logic [2:0]      sync2_q;
  logic [1:0]      row_q;
  logic [3:0]      key_row_q;
  logic [DW_W-1:0] dwell_q;
  logic [DB_W-1:0] db_q;
  logic [RL_W-1:0] rel_q;
  logic [1:0]      col_idx_q;
  logic [2:0]      pat_q;
  logic [3:0]      code_q;
  logic            valid_q;
  logic            held_q;

  logic [2:0] col_s;
  logic [2:0] low_d;
  logic       one_low_d;
  logic [1:0] col_idx_d;
  logic [1:0] row_nxt_d;
  logic [3:0] row_drive_d;
  logic [3:0] code_d;

  assign col_s = sync2_q;

  always_comb begin
    low_d       = ~col_s;
    one_low_d   = (low_d == 3'b001) || (low_d == 3'b010) || (low_d == 3'b100);
    col_idx_d   = low_d[0] ? 2'd0 : (low_d[1] ? 2'd1 : 2'd2);
    row_nxt_d   = row_q + 2'd1;
    row_drive_d = ~(4'b0001 << row_nxt_d);
  end

  // Row 3 carries the non-numeric keys, so it is mapped explicitly.
  always_comb begin
    code_d = 4'b0000;
    case ({row_q, col_idx_q})
      4'b00_00: code_d = 4'd1;
      4'b00_01: code_d = 4'd2;
      4'b00_10: code_d = 4'd3;
      4'b01_00: code_d = 4'd4;
      4'b01_01: code_d = 4'd5;
      4'b01_10: code_d = 4'd6;
      4'b10_00: code_d = 4'd7;
      4'b10_01: code_d = 4'd8;
      4'b10_10: code_d = 4'd9;
      4'b11_00: code_d = 4'b1110;
      4'b11_01: code_d = 4'b0000;
      4'b11_10: code_d = 4'b1111;
      default:  code_d = 4'b0000;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_SCAN;
      sync1_q   <= '1;
      sync2_q   <= '1;
      row_q     <= '0;
      key_row_q <= 4'b1110;
      dwell_q   <= '0;
      db_q      <= '0;
      rel_q     <= '0;
      col_idx_q <= '0;
      pat_q     <= '1;
      code_q    <= '0;
      valid_q   <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      sync1_q <= key_col;
      sync2_q <= sync1_q;
      valid_q <= 1'b0;
      case (state_q)
        ST_SCAN: begin
          if (dwell_q == DW_LAST) begin
            dwell_q <= '0;
            if (one_low_d) begin
              col_idx_q <= col_idx_d;
              pat_q     <= col_s;
              db_q      <= '0;
              state_q   <= ST_DEBOUNCE;
            end else begin
              row_q     <= row_nxt_d;
              key_row_q <= row_drive_d;
            end
          end else begin
            dwell_q <= dwell_q + DW_W'(1);
          end
        end
        ST_DEBOUNCE: begin
          if (col_s == pat_q) begin
            if (db_q == DB_LAST) begin
              code_q  <= code_d;
              valid_q <= 1'b1;
              held_q  <= 1'b1;
              rel_q   <= '0;
              state_q <= ST_HELD;
            end else begin
              db_q <= db_q + DB_W'(1);
            end
          end else begin
            state_q   <= ST_SCAN;
            dwell_q   <= '0;
            row_q     <= row_nxt_d;
            key_row_q <= row_drive_d;
          end
        end
        ST_HELD: begin
          // Any low column, including a second key, restarts the release count.
          if (col_s == 3'b111) begin
            if (rel_q == RL_LAST) begin
              held_q    <= 1'b0;
              state_q   <= ST_SCAN;
              dwell_q   <= '0;
              row_q     <= row_nxt_d;
              key_row_q <= row_drive_d;
            end else begin
              rel_q <= rel_q + RL_W'(1);
            end
          end else begin
            rel_q <= '0;
          end
        end
        default: state_q <= ST_SCAN;
      endcase
    end
  end

  assign key_row      = key_row_q;
  assign keypad_input = code_q;
  assign keypad_valid = valid_q;
  assign key_held     = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a keypad model closes column lines for
// pressed keys on the currently driven row.
module tb_keypad_scanner;

  localparam int RELEASE_DB = 20;
  localparam int K1 = 0, K3 = 2, K5 = 4, K8 = 7, K9 = 8, KSTAR = 9, KHASH = 11;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] key_col;
  logic [3:0] key_row;
  logic [3:0] keypad_input;
  logic       keypad_valid;
  logic       key_held;
  logic [11:0] press;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int npulse = 0;
  int nconsec = 0;
  logic prev_v = 1'b0;
  logic [3:0] pcode [16];
  int ptime [16];

  keypad_scanner #(.SCAN_DWELL(4), .DEBOUNCE(20), .RELEASE_DB(RELEASE_DB)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .key_col(key_col),
    .key_row(key_row),
    .keypad_input(keypad_input),
    .keypad_valid(keypad_valid),
    .key_held(key_held)
  );

  always #5 clk = ~clk;

  always_comb begin
    key_col = 3'b111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (press[r*3+c] && !key_row[r]) key_col[c] = 1'b0;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (keypad_valid) begin
      if (npulse < 16) begin
        pcode[npulse] = keypad_input;
        ptime[npulse] = cyc;
      end
      if (prev_v) nconsec++;
      npulse++;
    end
    prev_v = keypad_valid;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_pulse(input int n0, input int budget);
    for (int i = 0; i < budget && npulse == n0; i++) tick(1);
    tick(1);
  endtask

  task automatic test_reset;
    logic [3:0] er;
    logic held_seen;
    press = '0;
    rst_n = 1'b0;
    tick(2);
    checks++; if (key_row !== 4'b1110) begin errors++; $display("FAIL reset_row: got %b expected 1110", key_row); end
    checks++; if (keypad_input !== 4'b0000) begin errors++; $display("FAIL reset_input: got %b expected 0000", keypad_input); end
    checks++; if (keypad_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", keypad_valid); end
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL reset_held: got %b expected 0", key_held); end
    rst_n = 1'b1;
    held_seen = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      tick(1);
      er = ~(4'b0001 << ((k / 4) % 4));
      if (key_held) held_seen = 1'b1;
      checks++; if (key_row !== er) begin errors++; $display("FAIL idle_row cycle %0d: got %b expected %b", k, key_row, er); end
    end
    checks++; if (npulse !== 0) begin errors++; $display("FAIL idle_pulses: got %0d expected 0", npulse); end
    checks++; if (held_seen !== 1'b0) begin errors++; $display("FAIL idle_held: got %b expected 0", held_seen); end
  endtask

  task automatic test_press_5;
    int n0;
    n0 = npulse;
    press[K5] = 1'b1;
    wait_pulse(n0, 110);
    checks++; if (npulse !== n0 + 1) begin errors++; $display("FAIL k5_pulse: got %0d pulses expected %0d", npulse, n0 + 1); end
    checks++; if (pcode[n0] !== 4'b0101) begin errors++; $display("FAIL k5_code: got %b expected 0101", pcode[n0]); end
    checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL k5_held: got %b expected 1", key_held); end
    tick(90);
    checks++; if (npulse !== n0 + 1) begin errors++; $display("FAIL k5_single: got %0d pulses expected %0d", npulse, n0 + 1); end
    checks++; if (keypad_input !== 4'b0101) begin errors++; $display("FAIL k5_hold_code: got %b expected 0101", keypad_input); end
    press[K5] = 1'b0;
    tick(21);
    checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL k5_rel21: got %b expected 1", key_held); end
    tick(1);
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL k5_rel22: got %b expected 0", key_held); end
    tick(10);
  endtask

  task automatic test_star_hash;
    int n0;
    n0 = npulse;
    press[KSTAR] = 1'b1; tick(60);
    press[KSTAR] = 1'b0; tick(60);
    press[KHASH] = 1'b1; tick(60);
    press[KHASH] = 1'b0; tick(40);
    checks++; if (npulse !== n0 + 2) begin errors++; $display("FAIL sh_count: got %0d pulses expected %0d", npulse, n0 + 2); end
    checks++; if (pcode[n0] !== 4'b1110) begin errors++; $display("FAIL sh_star: got %b expected 1110", pcode[n0]); end
    checks++; if (pcode[n0+1] !== 4'b1111) begin errors++; $display("FAIL sh_hash: got %b expected 1111", pcode[n0+1]); end
    checks++; if (ptime[n0+1] - ptime[n0] < RELEASE_DB) begin errors++; $display("FAIL sh_gap: got %0d cycles expected >= %0d", ptime[n0+1] - ptime[n0], RELEASE_DB); end
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL sh_held: got %b expected 0", key_held); end
  endtask

  task automatic test_bounce_8;
    int n0;
    n0 = npulse;
    for (int i = 0; i < 10; i++) begin
      press[K8] = ~press[K8];
      tick(3);
    end
    checks++; if (npulse !== n0) begin errors++; $display("FAIL b8_early: got %0d pulses expected %0d", npulse, n0); end
    press[K8] = 1'b1;
    wait_pulse(n0, 60);
    tick(5);
    checks++; if (npulse !== n0 + 1) begin errors++; $display("FAIL b8_pulse: got %0d pulses expected %0d", npulse, n0 + 1); end
    checks++; if (pcode[n0] !== 4'b1000) begin errors++; $display("FAIL b8_code: got %b expected 1000", pcode[n0]); end
    press[K8] = 1'b0; tick(8);
    press[K8] = 1'b1; tick(2);
    press[K8] = 1'b0; tick(15);
    checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL b8_glitch_held: got %b expected 1", key_held); end
    tick(25);
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL b8_released: got %b expected 0", key_held); end
    checks++; if (npulse !== n0 + 1) begin errors++; $display("FAIL b8_retrigger: got %0d pulses expected %0d", npulse, n0 + 1); end
  endtask

  task automatic test_chord;
    int n0;
    logic saw_r1;
    n0 = npulse;
    saw_r1 = 1'b0;
    press[K1] = 1'b1;
    press[K3] = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (key_row == 4'b1101) saw_r1 = 1'b1;
    end
    checks++; if (npulse !== n0) begin errors++; $display("FAIL chord_nopulse: got %0d pulses expected %0d", npulse, n0); end
    checks++; if (saw_r1 !== 1'b1) begin errors++; $display("FAIL chord_scan: got %b expected 1", saw_r1); end
    press[K3] = 1'b0;
    wait_pulse(n0, 60);
    checks++; if (npulse !== n0 + 1) begin errors++; $display("FAIL chord_pulse: got %0d pulses expected %0d", npulse, n0 + 1); end
    checks++; if (pcode[n0] !== 4'b0001) begin errors++; $display("FAIL chord_code: got %b expected 0001", pcode[n0]); end
    press = '0;
    tick(30);
  endtask

  task automatic test_reset_abort;
    int n0;
    n0 = npulse;
    for (int i = 0; i < 20 && key_row == 4'b1011; i++) tick(1);
    press[K9] = 1'b1;
    for (int i = 0; i < 40 && key_row != 4'b1011; i++) tick(1);
    tick(13);
    rst_n = 1'b0;
    #1;
    checks++; if (key_row !== 4'b1110) begin errors++; $display("FAIL abort_row: got %b expected 1110", key_row); end
    checks++; if (keypad_input !== 4'b0000) begin errors++; $display("FAIL abort_input: got %b expected 0000", keypad_input); end
    checks++; if (keypad_valid !== 1'b0 || key_held !== 1'b0) begin errors++; $display("FAIL abort_flags: got valid %b held %b expected 0 0", keypad_valid, key_held); end
    checks++; if (npulse !== n0) begin errors++; $display("FAIL abort_nopulse: got %0d pulses expected %0d", npulse, n0); end
    tick(3);
    rst_n = 1'b1;
    wait_pulse(n0, 60);
    checks++; if (npulse !== n0 + 1) begin errors++; $display("FAIL abort_pulse: got %0d pulses expected %0d", npulse, n0 + 1); end
    checks++; if (pcode[n0] !== 4'b1001) begin errors++; $display("FAIL abort_code: got %b expected 1001", pcode[n0]); end
    press = '0;
    tick(30);
  endtask

  initial begin
    press = '0;
    rst_n = 1'b0;
    test_reset;
    test_press_5;
    test_star_hash;
    test_bounce_8;
    test_chord;
    test_reset_abort;
    checks++; if (nconsec !== 0) begin errors++; $display("FAIL valid_consecutive: got %0d expected 0", nconsec); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
